// File: rtl/kcpsm6_rgb_pkg.sv
// Shared constants for the KCPSM6 RGB peripheral: port map, status bit layout, digit width.
package kcpsm6_rgb_pkg;

  typedef logic [7:0] port_addr_t;

  localparam port_addr_t PA_PBTNS      = 8'h00;
  localparam port_addr_t PA_DIG_BASE   = 8'h01;
  localparam port_addr_t PA_RED        = 8'h0A;
  localparam port_addr_t PA_GREEN      = 8'h0B;
  localparam port_addr_t PA_BLUE       = 8'h0C;
  localparam port_addr_t PA_RGB_COMMIT = 8'h0D;
  localparam port_addr_t PA_IRQ_STAT   = 8'h0E;
  localparam port_addr_t PA_IRQ_EN     = 8'h0F;
  localparam port_addr_t PA_TICK_LO    = 8'h10;
  localparam port_addr_t PA_TICK_HI    = 8'h11;

  localparam int unsigned TICK_BIT = 0;
  localparam int unsigned BTN_BIT0 = 1;
  localparam int unsigned DIG_W    = 5;

endpackage

// File: rtl/kcpsm6_rgb_periph_if.sv
// KCPSM6 port bus: core drives address/data/strobes, peripheral returns read data and IRQ.
interface kcpsm6_rgb_periph_if;
  import kcpsm6_rgb_pkg::*;

  port_addr_t port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/kcpsm6_rgb_periph_tick_timer.sv
// Programmable periodic tick: prescaler feeding a period counter, with a low-byte shadow
// so the 16-bit period is loaded atomically by the high-byte write.
module kcpsm6_tick_timer #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned TICK_DEFAULT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  out_port,
  output logic        tick_evt,
  output logic [15:0] period
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   period_q, period_d;
  logic [7:0]    lo_q, lo_d;
  logic          pre_pulse;
  logic          tick_d;

  // Next-state for counters and period registers; a period reload restarts both counters.
  always_comb begin
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    lo_d      = lo_q;
    pre_pulse = 1'b0;
    tick_d    = 1'b0;

    if (wr_lo) lo_d = out_port;

    if (period_q == '0) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      if (presc_q == PRE_LAST) begin
        presc_d   = '0;
        pre_pulse = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (pre_pulse) begin
        if (cnt_q == period_q - 16'd1) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

    if (wr_hi) begin
      period_d = {out_port, lo_q};
      presc_d  = '0;
      cnt_d    = '0;
    end
  end

  // State registers with synchronous reset to the default period.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      period_q <= 16'(TICK_DEFAULT);
      lo_q     <= '0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      lo_q     <= lo_d;
    end
  end

  assign tick_evt = tick_d;
  assign period   = period_q;

endmodule

// File: rtl/kcpsm6_rgb_periph.sv
// KCPSM6 I/O peripheral: digit and committed-RGB registers, tick timer, button edge capture,
// masked W1C interrupt controller and registered read mux.
module kcpsm6_rgb_periph
  import kcpsm6_rgb_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned NUM_BTNS      = 5,
  parameter int unsigned COLOR_W       = 4,
  parameter int unsigned PRESCALE      = 1000,
  parameter int unsigned TICK_DEFAULT  = 50000,
  parameter port_addr_t  P_PBTNS       = PA_PBTNS,
  parameter port_addr_t  P_DIG_BASE    = PA_DIG_BASE,
  parameter port_addr_t  P_RED         = PA_RED,
  parameter port_addr_t  P_GREEN       = PA_GREEN,
  parameter port_addr_t  P_BLUE        = PA_BLUE,
  parameter port_addr_t  P_RGB_COMMIT  = PA_RGB_COMMIT,
  parameter port_addr_t  P_IRQ_STAT    = PA_IRQ_STAT,
  parameter port_addr_t  P_IRQ_EN      = PA_IRQ_EN,
  parameter port_addr_t  P_TICK_LO     = PA_TICK_LO,
  parameter port_addr_t  P_TICK_HI     = PA_TICK_HI
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BTNS-1:0]           db_btns,
  output logic [DIG_W*NUM_DIGITS-1:0]   dig,
  output logic [3*COLOR_W-1:0]          rgb,
  output logic                          rgb_update,
  kcpsm6_rgb_periph_if.slave            bus
);

  localparam int unsigned SW = NUM_BTNS + 1;

  logic             we;
  logic             wr_red, wr_green, wr_blue, wr_commit;
  logic             wr_stat, wr_en, wr_lo, wr_hi;
  logic             tick_evt;
  logic [15:0]      period;
  logic             unused_read_strobe;

  logic [DIG_W-1:0]     dig_q [NUM_DIGITS];
  logic [DIG_W-1:0]     dig_d [NUM_DIGITS];
  logic [COLOR_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 rgb_update_q, rgb_update_d;
  logic [NUM_BTNS-1:0]  prev_q, prev_d;
  logic [NUM_BTNS-1:0]  btn_evt;
  logic [SW-1:0]        evt;
  logic [SW-1:0]        pend_q, pend_d;
  logic [7:0]           en_q, en_d;
  logic                 irq_q, irq_d;
  logic [7:0]           in_port_q, in_port_d;

  // Reads have no side effects, so the read strobe is deliberately not used.
  assign unused_read_strobe = bus.read_strobe;

  // Write decode for the single-address registers.
  always_comb begin
    we        = bus.write_strobe | bus.k_write_strobe;
    wr_red    = we && (bus.port_id == P_RED);
    wr_green  = we && (bus.port_id == P_GREEN);
    wr_blue   = we && (bus.port_id == P_BLUE);
    wr_commit = we && (bus.port_id == P_RGB_COMMIT);
    wr_stat   = we && (bus.port_id == P_IRQ_STAT);
    wr_en     = we && (bus.port_id == P_IRQ_EN);
    wr_lo     = we && (bus.port_id == P_TICK_LO);
    wr_hi     = we && (bus.port_id == P_TICK_HI);
  end

  kcpsm6_tick_timer #(
    .PRESCALE     (PRESCALE),
    .TICK_DEFAULT (TICK_DEFAULT)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .wr_lo    (wr_lo),
    .wr_hi    (wr_hi),
    .out_port (bus.out_port),
    .tick_evt (tick_evt),
    .period   (period)
  );

  // Digit registers: the lowest digit address maps to the most significant digit.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) dig_d[i] = dig_q[i];
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (we && (bus.port_id == 8'(P_DIG_BASE + k)))
        dig_d[NUM_DIGITS-1-k] = bus.out_port[DIG_W-1:0];
    end
  end

  // Flatten digit registers onto the output bus.
  always_comb begin
    dig = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) dig[i*DIG_W +: DIG_W] = dig_q[i];
  end

  // Colour shadows and atomic commit into the visible RGB value.
  always_comb begin
    red_d        = wr_red   ? bus.out_port[COLOR_W-1:0] : red_q;
    green_d      = wr_green ? bus.out_port[COLOR_W-1:0] : green_q;
    blue_d       = wr_blue  ? bus.out_port[COLOR_W-1:0] : blue_q;
    rgb_d        = wr_commit ? {red_q, green_q, blue_q} : rgb_q;
    rgb_update_d = wr_commit;
  end

  // Button edges, pending status with set-over-clear, and the interrupt request.
  always_comb begin
    prev_d            = db_btns;
    btn_evt           = db_btns & ~prev_q;
    evt               = '0;
    evt[TICK_BIT]     = tick_evt;
    evt[BTN_BIT0 +: NUM_BTNS] = btn_evt;

    pend_d = pend_q;
    if (wr_stat) pend_d = pend_d & ~bus.out_port[SW-1:0];
    pend_d = pend_d | evt;

    en_d = wr_en ? bus.out_port : en_q;

    irq_d = irq_q;
    if (bus.interrupt_ack) irq_d = 1'b0;
    if (|(evt & en_q[SW-1:0])) irq_d = 1'b1;
  end

  // Registered read mux, refreshed every cycle.
  always_comb begin
    in_port_d = '0;
    if      (bus.port_id == P_PBTNS)    in_port_d = 8'(db_btns);
    else if (bus.port_id == P_IRQ_STAT) in_port_d = 8'(pend_q);
    else if (bus.port_id == P_IRQ_EN)   in_port_d = en_q;
    else if (bus.port_id == P_TICK_LO)  in_port_d = period[7:0];
    else if (bus.port_id == P_TICK_HI)  in_port_d = period[15:8];
  end

  // Previous-button sample tracks the input even during reset so held buttons raise no event.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  // Main register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q        <= '{default: '0};
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      rgb_q        <= '0;
      rgb_update_q <= 1'b0;
      pend_q       <= '0;
      en_q         <= 8'h01;
      irq_q        <= 1'b0;
      in_port_q    <= '0;
    end else begin
      dig_q        <= dig_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      rgb_q        <= rgb_d;
      rgb_update_q <= rgb_update_d;
      pend_q       <= pend_d;
      en_q         <= en_d;
      irq_q        <= irq_d;
      in_port_q    <= in_port_d;
    end
  end

  assign rgb           = rgb_q;
  assign rgb_update    = rgb_update_q;
  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_kcpsm6_rgb_periph.sv
// Directed self-checking bench for kcpsm6_rgb_periph (PRESCALE=4, other parameters default).
module tb_kcpsm6_rgb_periph;

  logic        clk;
  logic        reset;
  logic [4:0]  db_btns;
  logic [39:0] dig;
  logic [11:0] rgb;
  logic        rgb_update;
  int          checks;
  int          failures;
  int          n;
  logic [7:0]  rd;

  kcpsm6_rgb_periph_if bus ();

  kcpsm6_rgb_periph #(
    .NUM_DIGITS   (8),
    .NUM_BTNS     (5),
    .COLOR_W      (4),
    .PRESCALE     (4),
    .TICK_DEFAULT (50000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db_btns    (db_btns),
    .dig        (dig),
    .rgb        (rgb),
    .rgb_update (rgb_update),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic write_port(input logic [7:0] addr, input logic [7:0] data);
    bus.port_id      = addr;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] addr, output logic [7:0] data);
    bus.port_id = addr;
    @(negedge clk);
    data = bus.in_port;
  endtask

  task automatic ack_irq();
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    db_btns = '0;
    bus.port_id = '0;
    bus.out_port = '0;
    bus.write_strobe = 1'b0;
    bus.k_write_strobe = 1'b0;
    bus.read_strobe = 1'b0;
    bus.interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_dig", dig, 40'h0);
    check_eq("rst_rgb", rgb, 12'h000);
    check_eq("rst_rgb_update", rgb_update, 1'b0);
    check_eq("rst_in_port", bus.in_port, 8'h00);
    check_eq("rst_interrupt", bus.interrupt, 1'b0);
    read_port(8'h10, rd); check_eq("rst_tick_lo", rd, 8'h50);
    read_port(8'h11, rd); check_eq("rst_tick_hi", rd, 8'hC3);
    read_port(8'h0F, rd); check_eq("rst_irq_en", rd, 8'h01);
    read_port(8'h0E, rd); check_eq("rst_irq_stat", rd, 8'h00);

    // Digits: k=0 -> top digit, k=7 -> digit 0, upper data bits dropped
    write_port(8'h01, 8'h15); check_eq("dig_k0", dig, 40'hA8_0000_0000);
    write_port(8'h08, 8'h1F); check_eq("dig_k7", dig, 40'hA8_0000_001F);
    write_port(8'h02, 8'hE3); check_eq("dig_k1_trunc", dig, 40'hA8_C000_001F);

    // Colour shadows then commit, via k_write_strobe for one of them
    write_port(8'h0A, 8'hFF);
    write_port(8'h0B, 8'h03);
    bus.port_id = 8'h0C; bus.out_port = 8'h09; bus.k_write_strobe = 1'b1;
    @(negedge clk);
    bus.k_write_strobe = 1'b0;
    check_eq("rgb_no_commit", rgb, 12'h000);
    check_eq("rgb_update_idle", rgb_update, 1'b0);
    write_port(8'h0D, 8'h00);
    check_eq("rgb_commit", rgb, 12'hF39);
    check_eq("rgb_update_pulse", rgb_update, 1'b1);
    @(negedge clk);
    check_eq("rgb_update_one_cycle", rgb_update, 1'b0);
    check_eq("rgb_hold", rgb, 12'hF39);

    // Tick period 3 with PRESCALE 4 -> event every 12 clocks
    write_port(8'h10, 8'h03);
    write_port(8'h11, 8'h00);
    n = 0;
    while (!bus.interrupt && n < 40) begin @(negedge clk); n++; end
    check_eq("tick_first_latency", n, 12);
    ack_irq(); n++;
    check_eq("tick_ack_clears", bus.interrupt, 1'b0);
    while (!bus.interrupt && n < 60) begin @(negedge clk); n++; end
    check_eq("tick_second_latency", n, 24);
    read_port(8'h0E, rd); check_eq("tick_pend", rd, 8'h01);
    read_port(8'h10, rd); check_eq("tick_lo_readback", rd, 8'h03);
    write_port(8'h10, 8'h00);
    write_port(8'h11, 8'h00);
    ack_irq();
    write_port(8'h0E, 8'h01);
    repeat (40) @(negedge clk);
    check_eq("tick_disabled_irq", bus.interrupt, 1'b0);
    read_port(8'h0E, rd); check_eq("tick_disabled_pend", rd, 8'h00);

    // Button 0 enabled only
    write_port(8'h0F, 8'h02);
    db_btns = 5'h01;
    @(negedge clk);
    check_eq("btn0_irq", bus.interrupt, 1'b1);
    db_btns = 5'h00;
    read_port(8'h0E, rd); check_eq("btn0_pend", rd, 8'h02);
    ack_irq();
    check_eq("btn0_ack", bus.interrupt, 1'b0);
    read_port(8'h0E, rd); check_eq("btn0_pend_after_ack", rd, 8'h02);
    write_port(8'h0E, 8'h02);
    read_port(8'h0E, rd); check_eq("btn0_w1c", rd, 8'h00);

    // Masked button 1: pending sets, no interrupt
    db_btns = 5'h02;
    @(negedge clk);
    db_btns = 5'h00;
    check_eq("btn1_masked_irq", bus.interrupt, 1'b0);
    read_port(8'h0E, rd); check_eq("btn1_masked_pend", rd, 8'h04);
    write_port(8'h0E, 8'h04);

    // Set wins over simultaneous W1C
    db_btns = 5'h01;
    write_port(8'h0E, 8'h02);
    db_btns = 5'h00;
    read_port(8'h0E, rd); check_eq("set_beats_clear", rd, 8'h02);
    check_eq("set_beats_clear_irq", bus.interrupt, 1'b1);

    // New enabled event in the same cycle as ack keeps interrupt high
    write_port(8'h0E, 8'h02);
    db_btns = 5'h01;
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
    db_btns = 5'h00;
    check_eq("ack_vs_event", bus.interrupt, 1'b1);
    ack_irq();
    write_port(8'h0E, 8'h3F);

    // Read map: live buttons, enable register, undecoded address
    db_btns = 5'h15;
    read_port(8'h00, rd); check_eq("rd_pbtns", rd, 8'h15);
    read_port(8'h0F, rd); check_eq("rd_irq_en", rd, 8'h02);
    read_port(8'h30, rd); check_eq("rd_undecoded", rd, 8'h00);

    // Reset with buttons held and a write in flight
    db_btns = 5'h1F;
    reset = 1'b1;
    bus.port_id = 8'h01; bus.out_port = 8'h1F; bus.write_strobe = 1'b1;
    repeat (3) @(negedge clk);
    bus.write_strobe = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst2_dig", dig, 40'h0);
    check_eq("rst2_rgb", rgb, 12'h000);
    check_eq("rst2_irq", bus.interrupt, 1'b0);
    read_port(8'h0E, rd); check_eq("rst2_no_pend", rd, 8'h00);
    read_port(8'h0F, rd); check_eq("rst2_irq_en", rd, 8'h01);
    read_port(8'h11, rd); check_eq("rst2_tick_hi", rd, 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kcpsm6_rgb_periph.md
# kcpsm6_rgb_periph

Parametrised KCPSM6 I/O peripheral for the Nexys4 RGB design: decodes port reads/writes to drive N seven-segment digit codes and an atomically committed RGB value of configurable colour depth. Adds a programmable periodic tick timer, per-button rising-edge capture, and a masked interrupt controller with write-1-to-clear status. Sits between the KCPSM6 core and the seven-segment driver and image controller.

## Interface
- NUM_DIGITS, 8: digit outputs, each 5 bits wide.
- NUM_BTNS, 5: debounced buttons; must be at most 7.
- COLOR_W, 4: bits per colour channel, 1..8.
- PRESCALE, 1000: clocks per prescaler pulse.
- TICK_DEFAULT, 50000: reset tick period in prescaler pulses; the default gives 2 Hz at 100 MHz.
- Port addresses:
  - PA_PBTNS 0x00
  - PA_DIG_BASE 0x01
  - PA_RED 0x0A
  - PA_GREEN 0x0B
  - PA_BLUE 0x0C
  - PA_RGB_COMMIT 0x0D
  - PA_IRQ_STAT 0x0E
  - PA_IRQ_EN 0x0F
  - PA_TICK_LO 0x10
  - PA_TICK_HI 0x11
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- db_btns  in  NUM_BTNS  debounced buttons, level-high.
- dig  out  5*NUM_DIGITS  digit codes; digit i occupies bits [5i+4:5i].
- rgb  out  3*COLOR_W  {R,G,B} committed colour.
- rgb_update  out  1  one-cycle pulse when rgb changes via commit.
- port_id  in  8  KCPSM6 port address.
- out_port  in  8  KCPSM6 write data.
- in_port  out  8  KCPSM6 read data, registered.
- write_strobe, k_write_strobe  in  1  write qualifiers; they are ORed.
- read_strobe  in  1  unused for side effects; reads are non-destructive.
- interrupt_ack  in  1  KCPSM6 interrupt acknowledge.
- interrupt  out  1  interrupt request.

## Operation
- **Digit writes:** a write to PA_DIG_BASE+k, for k in 0..NUM_DIGITS-1, loads digit NUM_DIGITS-1-k from out_port[4:0].
- **Colour writes:** writes to PA_RED, PA_GREEN and PA_BLUE load shadow registers from out_port[COLOR_W-1:0]. Upper bits are ignored.
- **Colour commit:** a write to PA_RGB_COMMIT with any data copies all three shadows to rgb and pulses rgb_update. rgb never shows a partially updated colour.
- **Tick period:**
  - A write to PA_TICK_LO loads a low-byte shadow.
  - A write to PA_TICK_HI sets period to {out_port, lo_shadow} and clears both counters.
- **Tick counters:**
  - The prescaler counts 0..PRESCALE-1 and emits one pre-pulse per wrap.
  - The period counter counts pre-pulses from 0..period-1; its wrap raises tick_evt for one cycle.
  - When period is 0, both counters hold at 0 and no tick events occur.
- **Button capture:**
  - btn_evt[i] = db_btns[i] & ~prev[i].
  - prev is loaded with db_btns every cycle, including during reset, so a button held through reset does not produce an event.
- **Interrupt status:**
  - Status byte layout: {pad, btn_pend[NUM_BTNS-1:0], tick_pend}.
  - A pending bit is set by its event.
  - A write to PA_IRQ_STAT clears the bits written as 1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Interrupt enable:** the enable register is written at PA_IRQ_EN and resets to 0x01 (tick only).
- **Interrupt request:**
  - interrupt sets when a new event arrives on an enabled bit.
  - It clears on interrupt_ack.
  - If an ack and a new enabled event occur in the same cycle, interrupt stays 1.
  - Pending bits are not cleared by the ack; software clears them with W1C.
- **Read map:**
  - PA_PBTNS: live zero-extended db_btns.
  - PA_IRQ_STAT: status byte.
  - PA_IRQ_EN: enable register.
  - PA_TICK_LO, PA_TICK_HI: the active period, not the shadow.
  - Any other address: 0x00.

## Timing
- **Reset values:**
  - dig = 0, rgb = 0, shadows = 0, rgb_update = 0.
  - in_port = 0x00, interrupt = 0.
  - Pending bits = 0, enable = 0x01.
  - period = TICK_DEFAULT; counters = 0.
- **Write latency:** every write takes effect at the clk edge that samples the strobe. rgb and rgb_update change at that edge.
- **Read latency:** in_port reflects port_id one cycle later, updated every cycle regardless of read_strobe. This meets the KCPSM6 two-cycle INPUT.
- **Tick cadence:** tick_evt pulses every PRESCALE*period clocks. The first pulse comes PRESCALE*period clocks after reset release or after a PA_TICK_HI write.
- **Event-to-interrupt latency:** pending bit and interrupt both rise 1 cycle after the event cycle.
- **Mid-operation reset:** reset overrides all in-flight writes and counters in the same cycle.

## Structure
- **Shared package (kcpsm6_rgb_pkg):**
  - Default port-address constants.
  - Status bit index constants: TICK_BIT = 0, BTN_BIT0 = 1.
  - Digit field width 5.
- **Sub-module:** kcpsm6_tick_timer, holding the prescaler, the period counter, the period/lo-shadow registers and reload.
  - Inputs: clk, reset, the write-decode strobes and out_port.
  - Outputs: tick_evt and the active period for readback.
- **Top level:** address decode, digit/RGB registers, edge capture, IRQ logic, read mux.

## Test plan
- Reset with NUM_DIGITS=8 -> all outputs 0 and period readback 0x50/0xC3. Then write 0x15 to 0x01 -> dig[39:35]=0x15, other digits unchanged.
- Write R=0xF, G=0x3, B=0x9 with no commit -> rgb stays 0x000. Then write 0x0D -> rgb=0xF39 and rgb_update high for exactly 1 cycle.
- PRESCALE=4, LO=0x03 then HI=0x00 -> tick_pend sets and interrupt rises every 12 clocks. Write 0x00 to both LO and HI -> no further ticks.
- IRQ_EN=0x02, pulse db_btns[0] -> pending 0x02 and interrupt=1. interrupt_ack -> interrupt=0 while status still reads 0x02. W1C 0x02 -> status 0x00.
- A button edge coinciding with W1C of the same bit -> bit remains 1. A new enabled event in the same cycle as interrupt_ack -> interrupt remains 1.
- Read undecoded port 0x30 -> in_port=0x00 next cycle. Hold db_btns=0x1F through reset -> no pending bits after release.
